// File: rtl/crc_stream_engine_if.sv
// rtl/crc_stream_engine_if.sv - input/output beat streams of the CRC stream engine
interface crc_stream_engine_if #(
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/crc_stream_engine.sv
// rtl/crc_stream_engine.sv - streaming CRC generator/appender and checker
module crc_stream_engine #(
    parameter int               DATA_W  = 8,
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = 16'h1021,
    parameter logic [CRC_W-1:0] INIT    = 16'hFFFF,
    parameter logic [CRC_W-1:0] XOR_OUT = 16'h0000,
    parameter logic [CRC_W-1:0] RESIDUE = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    crc_stream_engine_if.slave   strm,
    output logic                 status_valid,
    output logic                 crc_ok,
    output logic [15:0]          err_cnt,
    output logic                 busy
);
    localparam int NCHUNK = CRC_W / DATA_W;
    localparam int CNT_W  = $clog2(NCHUNK + 1);

    typedef enum logic [1:0] {IDLE, DATA, APPEND} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CRC_W-1:0]   crc_q;
    logic               mode_q;
    logic [CNT_W-1:0]   chunk_cnt;
    logic               out_valid_q;
    logic [DATA_W-1:0]  out_data_q;
    logic               out_last_q;

    logic               in_ready_w;
    logic               in_fire;
    logic               out_fire;
    logic               first_beat;
    logic               frame_check;
    logic [CRC_W-1:0]   crc_next;
    logic [CRC_W-1:0]   crc_fin;
    logic               append_slot;

    // MSB-first, non-reflected CRC update over one whole beat
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c_in,
                                                  input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] c;
        c = c_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (c[CRC_W-1] ^ d[i]) c = (c << 1) ^ POLY;
            else                   c = c << 1;
        end
        return c;
    endfunction

    // Input is blocked during append, while the output register is full, and in reset
    assign in_ready_w  = !reset && (state != APPEND) && (!out_valid_q || strm.out_ready);
    assign in_fire     = strm.in_valid && in_ready_w;
    assign out_fire    = out_valid_q && strm.out_ready;
    assign first_beat  = (state == IDLE);
    assign frame_check = first_beat ? mode : mode_q;
    assign crc_next    = crc_step(first_beat ? INIT : crc_q, strm.in_data);
    assign crc_fin     = crc_q ^ XOR_OUT;
    assign append_slot = (state == APPEND) && (chunk_cnt != CNT_W'(NCHUNK))
                         && (!out_valid_q || strm.out_ready);

    assign strm.in_ready  = in_ready_w;
    assign strm.out_valid = out_valid_q;
    assign strm.out_data  = out_data_q;
    assign strm.out_last  = out_last_q;
    assign busy           = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: frames end in IDLE (check) or go through APPEND (generate)
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_fire) begin
                    if (!strm.in_last)     state_nxt = DATA;
                    else if (!frame_check) state_nxt = APPEND;
                end
            end
            DATA: begin
                if (in_fire && strm.in_last) state_nxt = frame_check ? IDLE : APPEND;
            end
            APPEND: begin
                if (out_fire && out_last_q) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: CRC register, output register, chunk counter, check verdict
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q        <= INIT;
            mode_q       <= 1'b0;
            chunk_cnt    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            status_valid <= 1'b0;
            crc_ok       <= 1'b0;
            err_cnt      <= 16'h0000;
        end else begin
            status_valid <= 1'b0;
            if (in_fire) begin
                crc_q       <= crc_next;
                out_valid_q <= 1'b1;
                out_data_q  <= strm.in_data;
                out_last_q  <= frame_check && strm.in_last;
                chunk_cnt   <= '0;
                if (first_beat) mode_q <= mode;
                if (frame_check && strm.in_last) begin
                    status_valid <= 1'b1;
                    crc_ok       <= (crc_next == RESIDUE);
                end
            end else if (append_slot) begin
                out_valid_q <= 1'b1;
                out_data_q  <= crc_fin[(NCHUNK - 1 - int'(chunk_cnt)) * DATA_W +: DATA_W];
                out_last_q  <= (chunk_cnt == CNT_W'(NCHUNK - 1));
                chunk_cnt   <= chunk_cnt + CNT_W'(1);
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
            if (status_valid && !crc_ok && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_crc_stream_engine.sv
// tb/tb_crc_stream_engine.sv - self-checking bench for crc_stream_engine
module tb_crc_stream_engine;
    logic        clk = 1'b0;
    logic        reset;
    logic        mode8, mode4;
    logic        status_valid8, crc_ok8, busy8;
    logic        status_valid4, crc_ok4, busy4;
    logic [15:0] err_cnt8, err_cnt4;

    crc_stream_engine_if #(.DATA_W(8)) if8 ();
    crc_stream_engine_if #(.DATA_W(4)) if4 ();

    crc_stream_engine u8 (
        .clk(clk), .reset(reset), .mode(mode8), .strm(if8),
        .status_valid(status_valid8), .crc_ok(crc_ok8), .err_cnt(err_cnt8), .busy(busy8)
    );

    crc_stream_engine #(.DATA_W(4)) u4 (
        .clk(clk), .reset(reset), .mode(mode4), .strm(if4),
        .status_valid(status_valid4), .crc_ok(crc_ok4), .err_cnt(err_cnt4), .busy(busy4)
    );

    always #5 clk = ~clk;

    typedef logic [8:0] beat_t;
    typedef logic [7:0] byte_q_t[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          rdy_mode = 0;
    int          gap_pct  = 0;
    beat_t       obs8[$], obs4[$], exp8[$], exp4[$];
    logic        st8[$], exp_st8[$];
    logic [15:0] exp_err  = 16'h0000;
    logic        stall8 = 1'b0, stall4 = 1'b0;
    beat_t       prev8, prev4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC: the whole frame as one MSB-first bit stream divided by the polynomial
    function automatic logic [15:0] ref_crc(input byte_q_t b, input int w);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (b[i]) begin
            for (int k = w - 1; k >= 0; k--) begin
                fb = c[15] ^ b[i][k];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    // Expected output beats, verdicts and error count for one frame
    function automatic void add_exp(input int w, input byte_q_t b, input bit m);
        logic [15:0] c;
        beat_t       e;
        int          n;
        c = ref_crc(b, w);
        n = 16 / w;
        foreach (b[i]) begin
            e = {m && (i == b.size() - 1), b[i]};
            if (w == 8) exp8.push_back(e);
            else        exp4.push_back(e);
        end
        if (!m) begin
            for (int j = 0; j < n; j++) begin
                e = {(j == n - 1), 8'((c >> (16 - w * (j + 1))) & ((1 << w) - 1))};
                if (w == 8) exp8.push_back(e);
                else        exp4.push_back(e);
            end
        end else begin
            exp_st8.push_back(c == 16'h0000);
            if (c != 16'h0000 && exp_err != 16'hFFFF) exp_err++;
        end
    endfunction

    // Ready pattern: 0 always ready, 1 toggle each cycle, 2 random
    initial begin
        if8.out_ready = 1'b1;
        if4.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       begin if8.out_ready = 1'b1; if4.out_ready = 1'b1; end
                1:       begin if8.out_ready = !if8.out_ready; if4.out_ready = !if4.out_ready; end
                default: begin if8.out_ready = 1'($urandom_range(1)); if4.out_ready = 1'($urandom_range(1)); end
            endcase
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitors: record transfers, check stability while stalled
    always @(negedge clk) begin
        if (reset) begin
            stall8 = 1'b0;
            stall4 = 1'b0;
        end else begin
            if (stall8) begin
                check("hold8_valid", if8.out_valid, 1);
                check("hold8_beat", {if8.out_last, if8.out_data}, prev8);
            end
            if (stall4) begin
                check("hold4_valid", if4.out_valid, 1);
                check("hold4_beat", {if4.out_last, 4'h0, if4.out_data}, prev4);
            end
            if (if8.out_valid && if8.out_ready) obs8.push_back({if8.out_last, if8.out_data});
            if (if4.out_valid && if4.out_ready) obs4.push_back({if4.out_last, 4'h0, if4.out_data});
            if (status_valid8) st8.push_back(crc_ok8);
            if (status_valid4) check("u4_status", status_valid4, 0);
            stall8 = if8.out_valid && !if8.out_ready;
            stall4 = if4.out_valid && !if4.out_ready;
            prev8  = {if8.out_last, if8.out_data};
            prev4  = {if4.out_last, 4'h0, if4.out_data};
        end
    end

    // Drive one frame; mode is only meaningful on the first beat, so later beats randomise it
    task automatic send(input int w, input byte_q_t b, input bit m, input bit with_last);
        logic r;
        int   t;
        for (int i = 0; i < b.size(); i++) begin
            if ($urandom_range(99) < gap_pct) begin
                if8.in_valid = 1'b0;
                if4.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            if (w == 8) begin
                if8.in_valid = 1'b1;
                if8.in_data  = b[i];
                if8.in_last  = with_last && (i == b.size() - 1);
                mode8        = (i == 0) ? m : 1'($urandom_range(1));
            end else begin
                if4.in_valid = 1'b1;
                if4.in_data  = b[i][3:0];
                if4.in_last  = with_last && (i == b.size() - 1);
                mode4        = (i == 0) ? m : 1'($urandom_range(1));
            end
            t = 0;
            forever begin
                @(negedge clk);
                r = (w == 8) ? if8.in_ready : if4.in_ready;
                @(posedge clk);
                #1;
                if (r) break;
                t++;
                if (t > 200) begin
                    check("in_ready_timeout", 0, 1);
                    break;
                end
            end
        end
        if8.in_valid = 1'b0;
        if4.in_valid = 1'b0;
        if8.in_last  = 1'b0;
        if4.in_last  = 1'b0;
        mode8 = (w == 8) ? m : mode8;
        mode4 = (w == 4) ? m : mode4;
    endtask

    // Wait for the expected output, compare everything and clear the queues
    task automatic check_drain(input int w, input string tag, output beat_t got[$]);
        int t;
        t = 0;
        if (w == 8) while (obs8.size() < exp8.size() && t < 400) begin @(posedge clk); t++; end
        else        while (obs4.size() < exp4.size() && t < 400) begin @(posedge clk); t++; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        if (w == 8) begin
            check({tag, "_nbeats"}, obs8.size(), exp8.size());
            for (int i = 0; i < exp8.size() && i < obs8.size(); i++)
                check($sformatf("%s_beat%0d", tag, i), obs8[i], exp8[i]);
            check({tag, "_nstat"}, st8.size(), exp_st8.size());
            for (int i = 0; i < exp_st8.size() && i < st8.size(); i++)
                check($sformatf("%s_ok%0d", tag, i), st8[i], exp_st8[i]);
            check({tag, "_err"}, err_cnt8, exp_err);
            check({tag, "_busy"}, busy8, 0);
            got = obs8;
            obs8.delete(); exp8.delete(); st8.delete(); exp_st8.delete();
        end else begin
            check({tag, "_nbeats"}, obs4.size(), exp4.size());
            for (int i = 0; i < exp4.size() && i < obs4.size(); i++)
                check($sformatf("%s_beat%0d", tag, i), obs4[i], exp4[i]);
            check({tag, "_busy"}, busy4, 0);
            got = obs4;
            obs4.delete(); exp4.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int w, input byte_q_t b, input bit m, input string tag,
                             output beat_t got[$]);
        add_exp(w, b, m);
        send(w, b, m, 1'b1);
        check_drain(w, tag, got);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string       s;
        byte_q_t     msg, good, bad, nib, f, fa, fb;
        beat_t       got[$];
        logic [15:0] c;
        int          c0, len;
        bit          m;

        s = "123456789";
        foreach (s[i]) msg.push_back(s[i]);
        good = msg; good.push_back(8'h29); good.push_back(8'hB1);
        bad  = msg; bad.push_back(8'h29);  bad.push_back(8'hB0);
        foreach (msg[i]) begin nib.push_back({4'h0, msg[i][7:4]}); nib.push_back({4'h0, msg[i][3:0]}); end

        reset = 1'b1;
        mode8 = 1'b0; mode4 = 1'b0;
        if8.in_valid = 1'b0; if8.in_data = '0; if8.in_last = 1'b0;
        if4.in_valid = 1'b0; if4.in_data = '0; if4.in_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", if8.out_valid, 0);
        check("rst_out_last", if8.out_last, 0);
        check("rst_out_data", if8.out_data, 0);
        check("rst_status", status_valid8, 0);
        check("rst_crc_ok", crc_ok8, 0);
        check("rst_err_cnt", err_cnt8, 0);
        check("rst_busy", busy8, 0);
        check("rst_in_ready", if8.in_ready, 0);
        check("rst_u4_valid", if4.out_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Standard generate frame, always ready
        run_frame(8, msg, 1'b0, "gen_std", got);
        if (got.size() == 11) begin
            check("gen_std_hi", got[9], 9'h029);
            check("gen_std_lo", got[10], 9'h1B1);
        end

        // Check mode: good and corrupted frame, verdict held afterwards
        run_frame(8, good, 1'b1, "chk_good", got);
        check("chk_good_crc_ok", crc_ok8, 1);
        run_frame(8, bad, 1'b1, "chk_bad", got);
        check("chk_bad_crc_ok", crc_ok8, 0);
        check("chk_bad_err", err_cnt8, 1);
        repeat (5) @(posedge clk);
        #1;
        check("crc_ok_hold", crc_ok8, 0);

        // Generate with out_ready toggling every cycle
        rdy_mode = 1;
        run_frame(8, msg, 1'b0, "gen_tog", got);
        if (got.size() == 11) begin
            check("gen_tog_hi", got[9], 9'h029);
            check("gen_tog_lo", got[10], 9'h1B1);
        end
        rdy_mode = 0;

        // Nibble-wide instance
        run_frame(4, nib, 1'b0, "gen_nib", got);
        if (got.size() == 22) begin
            check("nib_c0", got[18], 9'h002);
            check("nib_c1", got[19], 9'h009);
            check("nib_c2", got[20], 9'h00B);
            check("nib_c3", got[21], 9'h101);
        end

        // Back-to-back check frames (incl. single-beat) take one cycle per beat
        fa = {8'h5A};
        fb = {8'h00};
        add_exp(8, fa, 1'b1); add_exp(8, good, 1'b1); add_exp(8, fb, 1'b1);
        c0 = cyc;
        send(8, fa, 1'b1, 1'b1); send(8, good, 1'b1, 1'b1); send(8, fb, 1'b1, 1'b1);
        check("b2b_chk_cycles", cyc - c0, 13);
        check_drain(8, "b2b_chk", got);

        // Back-to-back generate frames: next frame accepted the cycle after the last chunk
        fa = {8'h11, 8'h22, 8'h33};
        fb = {8'h44, 8'h55};
        add_exp(8, fa, 1'b0); add_exp(8, fb, 1'b0);
        c0 = cyc;
        send(8, fa, 1'b0, 1'b1); send(8, fb, 1'b0, 1'b1);
        check("b2b_gen_cycles", cyc - c0, 8);
        check_drain(8, "b2b_gen", got);

        // Reset after the 5th data beat of a generate frame
        f = msg[0:4];
        send(8, f, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", if8.in_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        obs8.delete(); st8.delete(); exp_err = 16'h0000;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("abort_no_out", obs8.size(), 0);
        check("abort_busy", busy8, 0);
        @(posedge clk);
        #1;
        run_frame(8, good, 1'b1, "post_rst", got);
        check("post_rst_crc_ok", crc_ok8, 1);

        // Randomised frames, modes, back-pressure and input gaps
        for (int k = 0; k < 30; k++) begin
            f.delete();
            len = $urandom_range(1, 10);
            m   = 1'($urandom_range(1));
            for (int i = 0; i < len; i++) f.push_back(8'($urandom));
            if (m && $urandom_range(1) == 1) begin
                c = ref_crc(f, 8);
                f.push_back(c[15:8]);
                f.push_back(c[7:0]);
            end
            rdy_mode = $urandom_range(2);
            gap_pct  = $urandom_range(40);
            run_frame(8, f, m, $sformatf("rnd%0d", k), got);
        end
        rdy_mode = 0;
        gap_pct  = 0;

        // Error counter saturation
        force u8.err_cnt = 16'hFFFE;
        @(posedge clk);
        #1;
        release u8.err_cnt;
        exp_err = 16'hFFFE;
        fb = {8'h00};
        run_frame(8, fb, 1'b1, "sat1", got);
        run_frame(8, fb, 1'b1, "sat2", got);
        check("sat_final", err_cnt8, 16'hFFFF);

        check("u4_err_cnt", err_cnt4, 0);
        check("u4_crc_ok", crc_ok4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/crc_stream_engine.md
CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8: beat width in bits, 1/2/4/8/16, CRC_W % DATA_W == 0.
REQ-002 SHALL have parameter CRC_W, default 16: CRC width, 8..32.
REQ-003 SHALL have parameter POLY, default 16'h1021: generator polynomial, implicit top bit omitted.
REQ-004 SHALL have parameter INIT, default 16'hFFFF: CRC register preset at frame start.
REQ-005 SHALL have parameter XOR_OUT, default 16'h0000: mask XORed onto the CRC before append.
REQ-006 SHALL have parameter RESIDUE, default 16'h0000: raw register value meaning "good" in check mode.
REQ-007 SHALL have port clk, input, 1: sole clock, rising edge; one clock domain only.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port mode, input, 1: 0 = generate/append, 1 = check.
REQ-010 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, DATA_W), in_last (input, 1): input stream.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, DATA_W), out_last (output, 1): output stream.
REQ-012 SHALL have ports status_valid (output, 1), crc_ok (output, 1): check-mode verdict.
REQ-013 SHALL have port err_cnt, output, 16: saturating count of failed check frames.
REQ-014 SHALL have port busy, output, 1: high while state != IDLE.

Function
REQ-015 Transfer SHALL occur on a rising edge when valid && ready, on both streams.
REQ-016 CRC SHALL be computed MSB-first, DATA_W bits per cycle, fully unrolled, non-reflected.
REQ-017 FSM states SHALL be IDLE, DATA, APPEND.
REQ-018 IDLE -> DATA on an accepted beat with in_last=0; IDLE -> APPEND on an accepted in_last beat in generate mode; IDLE stays in IDLE on an accepted in_last beat in check mode.
REQ-019 DATA -> APPEND on accepted in_last (generate); DATA -> IDLE on accepted in_last (check).
REQ-020 APPEND -> IDLE when the final CRC chunk is transferred on the output.
REQ-021 mode SHALL be sampled on the first beat of a frame; changes mid-frame SHALL be ignored.
REQ-022 The first beat of a frame SHALL use INIT as the CRC base; subsequent beats use the running register.
REQ-023 in_ready SHALL equal (state != APPEND) && (!out_valid || out_ready), combinationally.
REQ-024 An accepted input beat SHALL appear on out_data on the next cycle (latency 1), unmodified.
REQ-025 While out_valid && !out_ready, out_data/out_last SHALL hold stable.
REQ-026 Generate mode: the appended value SHALL be crc ^ XOR_OUT, emitted as CRC_W/DATA_W beats, most-significant chunk first; a chunk counter SHALL track progress.
REQ-027 Generate mode: out_last SHALL be 0 on data beats and 1 only on the final CRC chunk.
REQ-028 Check mode: out_last SHALL mirror in_last; no beats are appended.
REQ-029 Check mode: status_valid SHALL pulse one cycle, the cycle after the in_last beat is accepted, with crc_ok = (raw register incl. that beat == RESIDUE).
REQ-030 On status_valid with crc_ok=0, err_cnt SHALL increment, saturating at 16'hFFFF.
REQ-031 crc_ok SHALL hold its value until the next status_valid.
REQ-032 A single-beat frame (in_last on first beat) SHALL be handled with no idle bubble.
REQ-033 Back-to-back frames SHALL be accepted with no gap in check mode; in generate mode the next frame is accepted the cycle after the final CRC chunk transfers.

Reset
REQ-034 On reset: state=IDLE, out_valid=0, out_last=0, out_data=0, status_valid=0, crc_ok=0, err_cnt=0, busy=0, CRC register=INIT, chunk counter=0.
REQ-035 Reset asserted mid-frame or mid-append SHALL discard the frame with no partial CRC emitted; in_ready SHALL be 0 while reset is high.

Verification
REQ-036 Defaults, generate, ASCII "123456789" as 9 beats, out_ready=1 -> outputs the 9 bytes then 8'h29, 8'hB1, out_last on 8'hB1; busy falls after.
REQ-037 Defaults, check, "123456789",8'h29,8'hB1 -> status_valid pulse, crc_ok=1, err_cnt=0; same frame with last byte 8'hB0 -> crc_ok=0, err_cnt=1.
REQ-038 Generate frame with out_ready toggled 1/0 every cycle, including during APPEND -> identical byte sequence to REQ-036, no drop or duplicate, outputs stable while stalled.
REQ-039 DATA_W=4, generate "123456789" as 18 nibbles -> CRC appended as nibbles 2,9,B,1.
REQ-040 Reset for one cycle after the 5th data beat, then a full check frame of REQ-037 -> no CRC beat from the aborted frame, crc_ok=1.
REQ-041 Force err_cnt to 16'hFFFE, send two failing check frames -> err_cnt 16'hFFFF and stays there.
